spi_peripheral_regfile: RTL and testbench
=========================================

# spi_peripheral_regfile

SPI peripheral (target) that answers an SPI controller's transactions with an internal register bank. It is the far end of the controller's four-wire link: it samples `spi_clk`/`cs_b`/`pico` with the fabric clock and drives `poci`. It is used as an on-FPGA loopback target and as a stand-in for ASIC configuration registers. Fabric logic sees every completed write and can read the bank through a local port.

## Interface
Parameters:
- `REG_WIDTH`, 8: bits per register and per SPI data word (8..32).
- `NUM_REGS`, 16: number of implemented registers (1..128). Addresses `>= NUM_REGS` are unimplemented.

Ports:
- `S_AXI_ACLK` in 1: fabric clock. Must run at least 8× `spi_clk`.
- `S_AXI_ARESET` in 1: asynchronous, active-high reset.
- `spi_clk` in 1: SPI clock from the controller, asynchronous, mode 0 (CPOL=0, CPHA=0).
- `cs_b` in 1: active-low chip select, asynchronous.
- `pico` in 1: controller-to-peripheral data, MSB first.
- `poci` out 1: peripheral-to-controller data, MSB first.
- `poci_oe` out 1: high while this block drives read data.
- `wr_valid` out 1: one-cycle strobe, one per completed write word.
- `wr_addr` out 7: register address of the strobed write.
- `wr_data` out REG_WIDTH: data of the strobed write.
- `loc_addr` in 7: local read address.
- `loc_rdata` out REG_WIDTH: registered bank contents at `loc_addr`. Returns 0 if unimplemented.
- `frame_err` out 1: one-cycle pulse when a frame ends mid-word.

## Operation
- Input capture: `spi_clk`, `cs_b` and `pico` each pass through a 2-flop synchronizer. Rise/fall detection uses a third flop on `spi_clk`.
  - A detected event acts one cycle later (3 clk after the pin edge).
  - Edges are ignored while synchronized `cs_b` is high.
- Frame format, MSB first:
  - One 8-bit command: bit7 R/W (1 = read), bits6:0 start address.
  - Then any number of `REG_WIDTH`-bit data words.
  - After each data word the address increments modulo 128.
- Bit sampling: `pico` is sampled on every detected rising edge. `bit_cnt` counts bits in the current word and wraps to 0 when the word completes.
- State machine:
  - IDLE: `cs_b` high. Falling `cs_b` → CMD with `bit_cnt` = 0.
  - CMD: on the 8th rising edge, latch address and R/W. Go to READ if R/W = 1, else WRITE. For READ, load `tx_sr` with reg[addr] in the same cycle.
  - WRITE: at each word completion:
    - If addr < `NUM_REGS`, write reg[addr] and pulse `wr_valid` with `wr_addr`/`wr_data` in the same cycle.
    - If unimplemented, drop the data and emit no strobe.
    - Then increment addr.
  - READ: at each word completion, increment addr and load `tx_sr` with reg[addr+1]. Unimplemented addresses load 0. Data on `pico` is ignored.
  - Any state: `cs_b` rising → IDLE. If `bit_cnt` ≠ 0 and the state is not IDLE, pulse `frame_err`. A partial word is never written.
- Transmit:
  - `poci` = `tx_sr[MSB]` in READ, else 0. `poci_oe` = 1 in READ.
  - A detected falling edge shifts `tx_sr` left only when `bit_cnt` ≠ 0. The falling edge right after a load therefore does not shift.
- Read data is captured at load time. A write to the same address within the same READ burst is impossible, since a frame is either read or write.
- `loc_rdata` is registered, with 1-cycle latency from `loc_addr`.

## Timing
- Reset (async assert, sync release), all values 0:
  - Outputs: `poci`, `poci_oe`, `wr_valid`, `wr_addr`, `wr_data`, `loc_rdata`, `frame_err`.
  - Internal: all registers, state = IDLE, `bit_cnt`, `tx_sr`, synchronizers.
- Reset mid-frame: the frame is abandoned with no strobe and no `frame_err`. The block then waits for a `cs_b` high→low sequence.
  - If `cs_b` is already low at release, stay in IDLE until `cs_b` rises.
- Write latency: `wr_valid` asserts 3 clk after the pin rising edge of the last data bit.
- Read setup: the first data MSB is on `poci` 3 clk after the 8th command rising edge. This is before the next rising edge when clk ≥ 8× `spi_clk`. Later bits follow each falling edge by 3 clk.
- Simultaneous events:
  - `cs_b` rise and `spi_clk` rise detected in the same cycle: `cs_b` wins and the edge is dropped.
  - Local reads in the same cycle as an SPI write return the old value. The new value appears the next cycle.

## Test plan
- Write reg 3: frame 0x03, 0xA5 → one `wr_valid` with `wr_addr`=3, `wr_data`=0xA5. Then `loc_addr`=3 gives `loc_rdata`=0xA5.
- Read reg 3: frame 0x83 + 8 clocks → controller receives 0xA5, `poci_oe` high only during the data phase, `poci`=0 afterwards.
- Burst write 0x0E, 0x11, 0x22, 0x33 (NUM_REGS=16) → regs 14 and 15 get 0x11 and 0x22. 0x33 goes to address 16, which is unimplemented: dropped with no third strobe.
- Read unimplemented address 0x85 with NUM_REGS=4 → 0x00 returned, no error.
- Abort: 0x02 then 5 data bits, then `cs_b` high → `frame_err` pulses once, no `wr_valid`, reg 2 unchanged.
- Reset asserted mid read burst, released while `cs_b` low → all outputs 0, no response until `cs_b` toggles. The next 0x83 read returns 0x00 (bank cleared).

Source files
------------

// File: rtl/spi_peripheral_regfile.sv
`default_nettype none
// ============================================================================
// Module   : spi_peripheral_regfile
// Brief    : Mode-0 SPI target answering reads/writes from a register bank,
//            with a write strobe and a registered local read port for fabric.
// Revision : 1.0 - initial release
// ============================================================================
module spi_peripheral_regfile #(
    parameter int REG_WIDTH = 8,
    parameter int NUM_REGS  = 16
) (
    input  logic                 S_AXI_ACLK,
    input  logic                 S_AXI_ARESET,
    input  logic                 spi_clk,
    input  logic                 cs_b,
    input  logic                 pico,
    output logic                 poci,
    output logic                 poci_oe,
    output logic                 wr_valid,
    output logic [6:0]           wr_addr,
    output logic [REG_WIDTH-1:0] wr_data,
    input  logic [6:0]           loc_addr,
    output logic [REG_WIDTH-1:0] loc_rdata,
    output logic                 frame_err
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_CMD   = 2'd1;
    localparam logic [1:0] c_WRITE = 2'd2;
    localparam logic [1:0] c_READ  = 2'd3;

    localparam int                 c_CNT_W     = $clog2(REG_WIDTH);
    localparam int                 c_IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [c_CNT_W-1:0] c_CMD_LAST  = c_CNT_W'(7);
    localparam logic [c_CNT_W-1:0] c_WORD_LAST = c_CNT_W'(REG_WIDTH - 1);
    localparam logic [7:0]         c_NUM_REGS  = 8'(NUM_REGS);

    // ------------------------------------------------------------------
    // Input synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [1:0] r_sclk_sync;
    logic       r_sclk_d;
    logic [1:0] r_cs_sync;
    logic       r_cs_d;
    logic [1:0] r_pico_sync;

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_sclk_sync <= '0;
            r_sclk_d    <= 1'b0;
            r_cs_sync   <= '0;
            r_cs_d      <= 1'b0;
            r_pico_sync <= '0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[0], spi_clk};
            r_sclk_d    <= r_sclk_sync[1];
            r_cs_sync   <= {r_cs_sync[0], cs_b};
            r_cs_d      <= r_cs_sync[1];
            r_pico_sync <= {r_pico_sync[0], pico};
        end
    end

    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_cs_rise;
    logic w_cs_fall;
    logic w_pico;

    // Gating SPI edges with synchronized cs_b also makes a same-cycle cs_b rise win.
    assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_d & ~r_cs_sync[1];
    assign w_sclk_fall = ~r_sclk_sync[1] & r_sclk_d & ~r_cs_sync[1];
    assign w_cs_rise   = r_cs_sync[1] & ~r_cs_d;
    assign w_cs_fall   = ~r_cs_sync[1] & r_cs_d;
    assign w_pico      = r_pico_sync[1];

    // ------------------------------------------------------------------
    // Register bank and frame state
    // ------------------------------------------------------------------
    logic [REG_WIDTH-1:0] r_regs [NUM_REGS];
    logic [1:0]           r_state;
    logic [c_CNT_W-1:0]   r_bit_cnt;
    logic [REG_WIDTH-2:0] r_rx_sr;
    logic [REG_WIDTH-1:0] r_tx_sr;
    logic [6:0]           r_addr;
    logic                 r_wr_valid;
    logic [6:0]           r_wr_addr;
    logic [REG_WIDTH-1:0] r_wr_data;
    logic                 r_frame_err;
    logic [REG_WIDTH-1:0] r_loc_rdata;

    function automatic logic [REG_WIDTH-1:0] read_bank(input logic [6:0] a);
        if ({1'b0, a} < c_NUM_REGS) begin
            return r_regs[a[c_IDX_W-1:0]];
        end
        return '0;
    endfunction

    function automatic logic is_impl(input logic [6:0] a);
        return ({1'b0, a} < c_NUM_REGS);
    endfunction

    logic                 w_cmd_rd;
    logic [6:0]           w_cmd_addr;
    logic [REG_WIDTH-1:0] w_word;
    logic [6:0]           w_addr_next;

    // The bit being sampled now completes either the command or a data word.
    assign w_cmd_rd    = r_rx_sr[6];
    assign w_cmd_addr  = {r_rx_sr[5:0], w_pico};
    assign w_word      = {r_rx_sr, w_pico};
    assign w_addr_next = r_addr + 7'd1;

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_state     <= c_IDLE;
            r_bit_cnt   <= '0;
            r_rx_sr     <= '0;
            r_tx_sr     <= '0;
            r_addr      <= '0;
            r_wr_valid  <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_frame_err <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_wr_valid  <= 1'b0;
            r_frame_err <= 1'b0;

            if (w_cs_rise) begin
                // A partial word is discarded; only a mid-word end is an error.
                if ((r_state != c_IDLE) && (r_bit_cnt != '0)) begin
                    r_frame_err <= 1'b1;
                end
                r_state   <= c_IDLE;
                r_bit_cnt <= '0;
            end else if (r_state == c_IDLE) begin
                if (w_cs_fall) begin
                    r_state   <= c_CMD;
                    r_bit_cnt <= '0;
                    r_tx_sr   <= '0;
                end
            end else if (w_sclk_rise) begin
                r_rx_sr <= {r_rx_sr[REG_WIDTH-3:0], w_pico};
                case (r_state)
                    c_CMD: begin
                        if (r_bit_cnt == c_CMD_LAST) begin
                            r_bit_cnt <= '0;
                            r_addr    <= w_cmd_addr;
                            if (w_cmd_rd) begin
                                r_state <= c_READ;
                                r_tx_sr <= read_bank(w_cmd_addr);
                            end else begin
                                r_state <= c_WRITE;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
                        end
                    end
                    c_WRITE: begin
                        if (r_bit_cnt == c_WORD_LAST) begin
                            r_bit_cnt <= '0;
                            r_addr    <= w_addr_next;
                            if (is_impl(r_addr)) begin
                                r_regs[r_addr[c_IDX_W-1:0]] <= w_word;
                                r_wr_valid <= 1'b1;
                                r_wr_addr  <= r_addr;
                                r_wr_data  <= w_word;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
                        end
                    end
                    c_READ: begin
                        if (r_bit_cnt == c_WORD_LAST) begin
                            r_bit_cnt <= '0;
                            r_addr    <= w_addr_next;
                            r_tx_sr   <= read_bank(w_addr_next);
                        end else begin
                            r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
                        end
                    end
                    default: begin
                        r_state <= c_IDLE;
                    end
                endcase
            end else if (w_sclk_fall && (r_bit_cnt != '0)) begin
                // The fall right after a load keeps the fresh MSB on the wire.
                r_tx_sr <= {r_tx_sr[REG_WIDTH-2:0], 1'b0};
            end
        end
    end

    // ------------------------------------------------------------------
    // Local read port
    // ------------------------------------------------------------------
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_loc_rdata <= '0;
        end else begin
            r_loc_rdata <= read_bank(loc_addr);
        end
    end

    assign poci      = (r_state == c_READ) & r_tx_sr[REG_WIDTH-1];
    assign poci_oe   = (r_state == c_READ);
    assign wr_valid  = r_wr_valid;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign frame_err = r_frame_err;
    assign loc_rdata = r_loc_rdata;

endmodule
`default_nettype wire

// File: tb/tb_spi_peripheral_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_peripheral_regfile
// Brief    : Self-checking bench: directed frame table, corner sequences and
//            random frames against a register-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_peripheral_regfile;

    localparam int RW = 8;
    localparam int NR = 16;

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          spi_clk  = 1'b0;
    logic          cs_b     = 1'b1;
    logic          pico     = 1'b0;
    logic [6:0]    loc_addr = 7'd0;
    logic          poci;
    logic          poci_oe;
    logic          wr_valid;
    logic [6:0]    wr_addr;
    logic [RW-1:0] wr_data;
    logic [RW-1:0] loc_rdata;
    logic          frame_err;

    spi_peripheral_regfile #(
        .REG_WIDTH (RW),
        .NUM_REGS  (NR)
    ) u_dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESET (rst),
        .spi_clk      (spi_clk),
        .cs_b         (cs_b),
        .pico         (pico),
        .poci         (poci),
        .poci_oe      (poci_oe),
        .wr_valid     (wr_valid),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .loc_addr     (loc_addr),
        .loc_rdata    (loc_rdata),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc    = 0;
    int unsigned last_rise_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [6:0]    a;
        logic [RW-1:0] d;
    } wr_t;

    wr_t         got_q[$];
    int unsigned got_cyc[$];
    int          fe_cnt = 0;
    logic        idle_drive = 1'b0;

    // Collects every write strobe and frame-error pulse, one sample per cycle.
    always @(negedge clk) begin
        if (wr_valid) begin
            got_q.push_back({wr_addr, wr_data});
            got_cyc.push_back(cyc);
        end
        if (frame_err) fe_cnt <= fe_cnt + 1;
        if (!poci_oe && poci) idle_drive <= 1'b1;
    end

    logic [RW-1:0] model [128];
    logic [RW-1:0] tx_words [4];
    logic [RW-1:0] rx_words [4];
    logic          oe_wrong;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [RW-1:0] model_rd(input int a);
        return (a < NR) ? model[a] : '0;
    endfunction

    task automatic spi_bit(input logic b, output logic r, output logic oe);
        pico = b;
        repeat (8) @(negedge clk);
        spi_clk = 1'b1;
        r  = poci;
        oe = poci_oe;
        last_rise_cyc = cyc;
        repeat (8) @(negedge clk);
        spi_clk = 1'b0;
    endtask

    task automatic spi_frame(input logic rd, input logic [6:0] a, input int n);
        logic       r;
        logic       oe;
        logic [7:0] cmd;
        oe_wrong = 1'b0;
        cs_b = 1'b0;
        repeat (8) @(negedge clk);
        cmd = {rd, a};
        for (int i = 7; i >= 0; i--) begin
            spi_bit(cmd[i], r, oe);
            if (oe !== 1'b0) oe_wrong = 1'b1;
        end
        for (int k = 0; k < n; k++) begin
            for (int i = RW - 1; i >= 0; i--) begin
                spi_bit(tx_words[k][i], r, oe);
                rx_words[k][i] = r;
                if (oe !== rd) oe_wrong = 1'b1;
            end
        end
        repeat (4) @(negedge clk);
        cs_b = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    // Expected strobes come from walking the address range, not from the DUT.
    task automatic check_writes(input string tag, input logic [6:0] a, input int n);
        wr_t exp_q[$];
        int  aa;
        for (int k = 0; k < n; k++) begin
            aa = (int'(a) + k) % 128;
            if (aa < NR) begin
                exp_q.push_back({7'(aa), tx_words[k]});
                model[aa] = tx_words[k];
            end
        end
        chk({tag, "_nstrobe"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk($sformatf("%s_strobe%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        end
    endtask

    task automatic check_reads(input string tag, input logic [6:0] a, input int n);
        for (int k = 0; k < n; k++) begin
            chk($sformatf("%s_word%0d", tag, k), 32'(rx_words[k]),
                32'(model_rd((int'(a) + k) % 128)));
        end
    endtask

    task automatic check_loc(input string tag, input logic [6:0] a);
        loc_addr = a;
        @(negedge clk);
        chk(tag, 32'(loc_rdata), 32'(model_rd(int'(a))));
    endtask

    function automatic logic [6:0] pick_addr();
        case ($urandom_range(0, 3))
            0:       return 7'($urandom_range(0, NR - 1));
            1:       return 7'($urandom_range(NR - 2, NR + 1));
            2:       return 7'($urandom_range(126, 127));
            default: return 7'($urandom_range(0, 127));
        endcase
    endfunction

    function automatic logic [31:0] outs();
        return 32'({poci, poci_oe, wr_valid, frame_err, wr_addr, wr_data, loc_rdata});
    endfunction

    typedef struct packed {
        logic                rd;
        logic [6:0]          addr;
        logic [2:0]          n;
        logic [3:0][RW-1:0]  d;     // write data, or expected read data
        logic [2:0]          nstb;  // expected write strobes
    } vec_t;

    localparam int NV = 8;
    vec_t vecs [NV];

    initial begin : timeout
        #2_000_000;
        $display("FAIL timeout: bench did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    initial begin : main
        int         fe_base;
        logic       r;
        logic       oe;
        logic [7:0] cmd;
        logic       rd_r;
        logic [6:0] a_r;
        int         n_r;

        vecs[0] = '{rd:1'b0, addr:7'h03, n:3'd1, d:{8'h00, 8'h00, 8'h00, 8'hA5}, nstb:3'd1};
        vecs[1] = '{rd:1'b1, addr:7'h03, n:3'd1, d:{8'h00, 8'h00, 8'h00, 8'hA5}, nstb:3'd0};
        vecs[2] = '{rd:1'b0, addr:7'h0E, n:3'd3, d:{8'h00, 8'h33, 8'h22, 8'h11}, nstb:3'd2};
        vecs[3] = '{rd:1'b1, addr:7'h0E, n:3'd3, d:{8'h00, 8'h00, 8'h22, 8'h11}, nstb:3'd0};
        vecs[4] = '{rd:1'b1, addr:7'h15, n:3'd1, d:{8'h00, 8'h00, 8'h00, 8'h00}, nstb:3'd0};
        vecs[5] = '{rd:1'b0, addr:7'h7F, n:3'd2, d:{8'h00, 8'h00, 8'hC3, 8'h5A}, nstb:3'd1};
        vecs[6] = '{rd:1'b1, addr:7'h7F, n:3'd2, d:{8'h00, 8'h00, 8'hC3, 8'h00}, nstb:3'd0};
        vecs[7] = '{rd:1'b1, addr:7'h05, n:3'd1, d:{8'h00, 8'h00, 8'h00, 8'h00}, nstb:3'd0};

        for (int i = 0; i < 128; i++) model[i] = '0;

        // Reset state
        @(negedge clk);
        chk("reset_outs_held", outs(), 32'd0);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("reset_outs_released", outs(), 32'd0);

        // Directed frame table
        for (int v = 0; v < NV; v++) begin
            for (int k = 0; k < 4; k++) tx_words[k] = vecs[v].d[k];
            got_q.delete();
            got_cyc.delete();
            fe_base = fe_cnt;
            spi_frame(vecs[v].rd, vecs[v].addr, int'(vecs[v].n));
            if (vecs[v].rd) begin
                for (int k = 0; k < int'(vecs[v].n); k++) begin
                    chk($sformatf("vec%0d_rdata%0d", v, k), 32'(rx_words[k]), 32'(vecs[v].d[k]));
                end
                check_reads($sformatf("vec%0d_model", v), vecs[v].addr, int'(vecs[v].n));
            end else begin
                chk($sformatf("vec%0d_strobes", v), 32'(got_q.size()), 32'(vecs[v].nstb));
                check_writes($sformatf("vec%0d", v), vecs[v].addr, int'(vecs[v].n));
            end
            if (v == 0) begin
                chk("wr_latency", (got_cyc.size() > 0) ? 32'(got_cyc[0] - last_rise_cyc) : 32'hFFFF_FFFF, 32'd3);
            end
            chk($sformatf("vec%0d_oe_phase", v), 32'(oe_wrong), 32'd0);
            chk($sformatf("vec%0d_idle_pins", v), 32'({poci, poci_oe}), 32'd0);
            chk($sformatf("vec%0d_no_frame_err", v), 32'(fe_cnt - fe_base), 32'd0);
        end

        check_loc("loc_reg3", 7'h03);
        check_loc("loc_reg14", 7'h0E);
        check_loc("loc_reg15", 7'h0F);
        check_loc("loc_reg0_wrapped", 7'h00);
        check_loc("loc_unimpl", 7'h14);

        // Abort mid-word: command 0x02 then 5 data bits
        got_q.delete();
        fe_base = fe_cnt;
        cs_b = 1'b0;
        repeat (8) @(negedge clk);
        cmd = 8'h02;
        for (int i = 7; i >= 0; i--) spi_bit(cmd[i], r, oe);
        for (int i = 0; i < 5; i++) spi_bit(1'b1, r, oe);
        repeat (4) @(negedge clk);
        cs_b = 1'b1;
        repeat (12) @(negedge clk);
        chk("abort_frame_err_once", 32'(fe_cnt - fe_base), 32'd1);
        chk("abort_no_strobe", 32'(got_q.size()), 32'd0);
        check_loc("abort_reg2_kept", 7'h02);

        // Reset mid read burst with cs_b held low through release
        got_q.delete();
        fe_base = fe_cnt;
        cs_b = 1'b0;
        repeat (8) @(negedge clk);
        cmd = 8'h83;
        for (int i = 7; i >= 0; i--) spi_bit(cmd[i], r, oe);
        for (int i = 0; i < 4; i++) spi_bit(1'b0, r, oe);
        chk("pre_reset_oe", 32'(poci_oe), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("async_reset_outs", outs(), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 128; i++) model[i] = '0;
        @(negedge clk);
        chk("post_reset_outs", outs(), 32'd0);
        // A write frame with no preceding cs_b fall must be ignored.
        oe_wrong = 1'b0;
        cmd = 8'h03;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(cmd[i], r, oe);
            if (oe !== 1'b0) oe_wrong = 1'b1;
        end
        for (int i = RW - 1; i >= 0; i--) begin
            spi_bit(i[0], r, oe);
            if (oe !== 1'b0) oe_wrong = 1'b1;
        end
        repeat (4) @(negedge clk);
        cs_b = 1'b1;
        repeat (12) @(negedge clk);
        chk("post_reset_ignored_strobe", 32'(got_q.size()), 32'd0);
        chk("post_reset_ignored_oe", 32'(oe_wrong), 32'd0);
        chk("post_reset_no_frame_err", 32'(fe_cnt - fe_base), 32'd0);
        tx_words[0] = 8'hFF;
        spi_frame(1'b1, 7'h03, 1);
        chk("post_reset_read_cleared", 32'(rx_words[0]), 32'd0);
        check_loc("post_reset_loc3", 7'h03);

        // Random frames against the reference model
        for (int t = 0; t < 24; t++) begin
            rd_r = 1'($urandom_range(0, 1));
            a_r  = pick_addr();
            n_r  = int'($urandom_range(1, 4));
            for (int k = 0; k < 4; k++) tx_words[k] = RW'($urandom);
            got_q.delete();
            fe_base = fe_cnt;
            spi_frame(rd_r, a_r, n_r);
            if (rd_r) check_reads($sformatf("rnd%0d_rd_a%0h", t, a_r), a_r, n_r);
            else      check_writes($sformatf("rnd%0d_wr_a%0h", t, a_r), a_r, n_r);
            chk($sformatf("rnd%0d_oe_phase", t), 32'(oe_wrong), 32'd0);
            chk($sformatf("rnd%0d_no_frame_err", t), 32'(fe_cnt - fe_base), 32'd0);
        end

        for (int t = 0; t < 10; t++) begin
            check_loc($sformatf("rnd_loc%0d", t), pick_addr());
        end

        chk("poci_only_when_oe", 32'(idle_drive), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
